tjpu_ctrl_shell: RTL and testbench

- Top-level control shell of the TJPU CNN accelerator: host-register command/status front-end, AXI-stream input/output steering and DMA start strobes for three engines (conv3x3, conv1x1, reshape).
- Each engine runs a parameter-load phase and a compute phase, sequenced by a host Control/State handshake.
- Compute datapath is a lane-wise int8 requantizer (1:1 beat mapping); the full MAC array is outside this block.

---
 rtl/tjpu_pkg.sv | 67 ++++++
 rtl/tjpu_engine_fsm.sv | 91 +++++++++
 rtl/tjpu_ctrl_shell.sv | 198 +++++++++++++++++++
 tb/tb_tjpu_ctrl_shell.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tjpu_pkg.sv
// Shared encodings, register field positions and the lane requantizer for the TJPU control shell.
package tjpu_pkg;

    // Engine state codes as seen by the host on State_* outputs.
    typedef enum logic [3:0] {
        StIdle = 4'b0000,
        StPara = 4'b0001,
        StComp = 4'b0010,
        StDone = 4'b1111
    } eng_state_e;

    // Host command codes on Control_3_3 / Control_1_1 / Control_RE[7:4].
    localparam logic [3:0] CmdNop  = 4'b0000;
    localparam logic [3:0] CmdPara = 4'b0001;
    localparam logic [3:0] CmdComp = 4'b0010;
    localparam logic [3:0] CmdAck  = 4'b1111;

    // Engine select codes on Switch.
    localparam logic [3:0] SwConv3   = 4'b0001;
    localparam logic [3:0] SwConv1   = 4'b0010;
    localparam logic [3:0] SwReshape = 4'b1000;

    // Reshape op codes on Control_RE[3:0].
    localparam logic [3:0] OpConcat   = 4'b0001;
    localparam logic [3:0] OpRoute    = 4'b0010;
    localparam logic [3:0] OpMaxpool  = 4'b0100;
    localparam logic [3:0] OpUpsample = 4'b1000;

    // Reg_4 fields.
    localparam int unsigned R4ParaHiLsb = 16;  // [31:16]
    localparam int unsigned R4ParaLoLsb = 8;   // [15:8]
    localparam int unsigned R4CinLsb    = 0;   // [10:0]
    localparam int unsigned R4WLsb      = 11;  // [21:11]
    localparam int unsigned R4CoutLsb   = 22;  // [31:22]
    localparam int unsigned DimW        = 11;  // width of Cin/W/H fields
    // Reg_5 fields.
    localparam int unsigned R5HLsb      = 0;   // [10:0]
    // Reg_6 fields.
    localparam int unsigned R6ScaleLsb  = 16;  // [31:16]
    localparam int unsigned R6ShiftLsb  = 0;   // [4:0]
    // Reg_7 fields.
    localparam int unsigned R7ZpLsb     = 16;  // [23:16]

    // y = sat8(((x * scale) >>> shamt) + zp), 24-bit signed product.
    function automatic logic [7:0] requant_lane(input logic [7:0]  x,
                                                input logic [15:0] scale,
                                                input logic [4:0]  shamt,
                                                input logic [7:0]  zp);
        logic signed [23:0] x_ext;
        logic signed [23:0] s_ext;
        logic signed [23:0] prod;
        logic signed [23:0] shifted;
        logic signed [24:0] sum;
        x_ext   = {{16{x[7]}}, x};
        s_ext   = {{8{scale[15]}}, scale};
        prod    = x_ext * s_ext;
        shifted = prod >>> shamt;
        sum     = {shifted[23], shifted} + {{17{zp[7]}}, zp};
        if (sum > 25'sd127) begin
            return 8'h7F;
        end else if (sum < -25'sd128) begin
            return 8'h80;
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/tjpu_engine_fsm.sv
// Per-engine sequencer: host command decode, state register, beat counter and DMA start strobes.
module tjpu_engine_fsm
    import tjpu_pkg::*;
#(
    parameter int unsigned AddrW = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel_i,
    input  logic [3:0]       cmd_i,
    input  logic             ack_alt_i,
    input  logic [31:0]      para_beats_i,
    input  logic [31:0]      comp_beats_i,
    input  logic             beat_i,
    output eng_state_e       state_o,
    output logic             dma_rd_o,
    output logic             dma_wr_o,
    output logic [AddrW-1:0] addr_o
);

    eng_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] total_q, total_d;
    logic        dma_rd_q, dma_rd_d;
    logic        dma_wr_q, dma_wr_d;

    // Next state, beat accounting and start strobes; the beat total is latched on entry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        total_d  = total_q;
        dma_rd_d = 1'b0;
        dma_wr_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (sel_i) begin
                    if (cmd_i == CmdPara) begin
                        state_d  = StPara;
                        cnt_d    = '0;
                        total_d  = para_beats_i;
                        dma_rd_d = 1'b1;
                    end else if (cmd_i == CmdComp) begin
                        state_d  = StComp;
                        cnt_d    = '0;
                        total_d  = comp_beats_i;
                        dma_rd_d = 1'b1;
                        dma_wr_d = 1'b1;
                    end
                end
            end
            StPara, StComp: begin
                if (sel_i && beat_i) begin
                    if (cnt_q == total_q - 32'd1) begin
                        state_d = StDone;
                    end
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDone: begin
                // Ack is honoured even while deselected.
                if (cmd_i == CmdAck || ack_alt_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            total_q  <= '0;
            dma_rd_q <= 1'b0;
            dma_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
            dma_rd_q <= dma_rd_d;
            dma_wr_q <= dma_wr_d;
        end
    end

    assign state_o  = state_q;
    assign dma_rd_o = dma_rd_q;
    assign dma_wr_o = dma_wr_q;
    assign addr_o   = cnt_q[AddrW-1:0];

endmodule

// File: rtl/tjpu_ctrl_shell.sv
// TJPU control shell: host command/status, stream steering, parameter store and int8 requantizer.
module tjpu_ctrl_shell
    import tjpu_pkg::*;
#(
    parameter int unsigned DATA_W             = 128,
    parameter int unsigned WIDTH_RAM_SIZE     = 12,
    parameter int unsigned WIDTH_FEATURE_SIZE = 12,
    parameter int unsigned WIDTH_CHANNEL_NUM  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        Switch,
    input  logic [3:0]        Control_3_3,
    input  logic [3:0]        Control_1_1,
    input  logic [7:0]        Control_RE,
    output logic [3:0]        State_3_3,
    output logic [3:0]        State_1_1,
    output logic [3:0]        State_RE,
    input  logic [31:0]       Reg_4,
    input  logic [31:0]       Reg_5,
    input  logic [31:0]       Reg_6,
    input  logic [31:0]       Reg_7,
    output logic              DMA_Read_Start,
    output logic              DMA_Write_Start,
    input  logic [DATA_W-1:0] S_Data,
    input  logic              S_Valid,
    output logic              S_Ready,
    output logic [DATA_W-1:0] M_Data,
    output logic              M_Valid,
    input  logic              M_Ready,
    input  logic              introut_3x3_Wr
);

    localparam int unsigned Lanes = DATA_W / 8;

    logic                          sel_c3, sel_c1, sel_re;
    eng_state_e                    st_c3, st_c1, st_re, sel_state;
    logic                          rd_c3, rd_c1, rd_re, wr_c3, wr_c1, wr_re;
    logic [WIDTH_RAM_SIZE-1:0]     addr_c3, addr_c1, addr_re, para_addr;
    logic                          accept, para_accept, comp_accept, pass_thru;
    logic [16:0]                   para_sum;
    logic [31:0]                   para_beats, comp_beats;
    logic [WIDTH_FEATURE_SIZE-1:0] feat_h, feat_w;
    logic [DimW-1:0]               cin;
    logic [WIDTH_CHANNEL_NUM-1:0]  cout;
    logic [39:0]                   comp_prod;
    logic [DATA_W-1:0]             lane_y;
    logic                          m_valid_q;
    logic [DATA_W-1:0]             m_data_q;
    logic [DATA_W-1:0]             param_mem [2**WIDTH_RAM_SIZE];
    logic [DATA_W-1:0]             unused_param_q;
    logic                          unused_bits;

    assign sel_c3 = (Switch == SwConv3);
    assign sel_c1 = (Switch == SwConv1);
    assign sel_re = (Switch == SwReshape);

    // Beat totals handed to whichever engine starts this cycle.
    always_comb begin
        para_sum   = {1'b0, Reg_4[R4ParaHiLsb +: 16]} + 17'(Reg_4[R4ParaLoLsb +: 8]);
        para_beats = (para_sum == 17'd0) ? 32'd1 : 32'(para_sum);
        cin        = Reg_4[R4CinLsb +: DimW];
        feat_w     = WIDTH_FEATURE_SIZE'(Reg_4[R4WLsb +: DimW]);
        feat_h     = WIDTH_FEATURE_SIZE'(Reg_5[R5HLsb +: DimW]);
        cout       = Reg_4[R4CoutLsb +: WIDTH_CHANNEL_NUM];
        comp_prod  = 40'(feat_h) * 40'(feat_w) * 40'(cin);
        comp_beats = (comp_prod[35:4] == 32'd0) ? 32'd1 : comp_prod[35:4];
    end

    tjpu_engine_fsm #(.AddrW(WIDTH_RAM_SIZE)) u_fsm_c3 (
        .clk          (clk),
        .rst          (rst),
        .sel_i        (sel_c3),
        .cmd_i        (Control_3_3),
        .ack_alt_i    (introut_3x3_Wr),
        .para_beats_i (para_beats),
        .comp_beats_i (comp_beats),
        .beat_i       (accept & sel_c3),
        .state_o      (st_c3),
        .dma_rd_o     (rd_c3),
        .dma_wr_o     (wr_c3),
        .addr_o       (addr_c3)
    );

    tjpu_engine_fsm #(.AddrW(WIDTH_RAM_SIZE)) u_fsm_c1 (
        .clk          (clk),
        .rst          (rst),
        .sel_i        (sel_c1),
        .cmd_i        (Control_1_1),
        .ack_alt_i    (1'b0),
        .para_beats_i (para_beats),
        .comp_beats_i (comp_beats),
        .beat_i       (accept & sel_c1),
        .state_o      (st_c1),
        .dma_rd_o     (rd_c1),
        .dma_wr_o     (wr_c1),
        .addr_o       (addr_c1)
    );

    tjpu_engine_fsm #(.AddrW(WIDTH_RAM_SIZE)) u_fsm_re (
        .clk          (clk),
        .rst          (rst),
        .sel_i        (sel_re),
        .cmd_i        (Control_RE[7:4]),
        .ack_alt_i    (1'b0),
        .para_beats_i (para_beats),
        .comp_beats_i (comp_beats),
        .beat_i       (accept & sel_re),
        .state_o      (st_re),
        .dma_rd_o     (rd_re),
        .dma_wr_o     (wr_re),
        .addr_o       (addr_re)
    );

    // Route the selected engine's state and parameter address onto the shared stream.
    always_comb begin
        sel_state = StIdle;
        para_addr = '0;
        case (Switch)
            SwConv3: begin
                sel_state = st_c3;
                para_addr = addr_c3;
            end
            SwConv1: begin
                sel_state = st_c1;
                para_addr = addr_c1;
            end
            SwReshape: begin
                sel_state = st_re;
                para_addr = addr_re;
            end
            default: ;
        endcase
    end

    // Input handshake; compute only pulls a beat when the output slot is free or draining.
    always_comb begin
        S_Ready     = (sel_state == StPara) ||
                      ((sel_state == StComp) && (!m_valid_q || M_Ready));
        accept      = S_Valid && S_Ready;
        para_accept = accept && (sel_state == StPara);
        comp_accept = accept && (sel_state == StComp);
    end

    // Reshape ops move data without rescaling; everything else is requantized.
    always_comb begin
        pass_thru = 1'b0;
        if (sel_re) begin
            case (Control_RE[3:0])
                OpConcat, OpRoute, OpMaxpool, OpUpsample: pass_thru = 1'b1;
                default: pass_thru = 1'b0;
            endcase
        end
    end

    // Lane-wise requantizer.
    always_comb begin
        lane_y = '0;
        for (int i = 0; i < Lanes; i++) begin
            lane_y[8*i +: 8] = pass_thru ? S_Data[8*i +: 8]
                             : requant_lane(S_Data[8*i +: 8], Reg_6[R6ScaleLsb +: 16],
                                            Reg_6[R6ShiftLsb +: 5], Reg_7[R7ZpLsb +: 8]);
        end
    end

    // Single-entry output register; holds while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else if (comp_accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= lane_y;
        end else if (M_Ready) begin
            m_valid_q <= 1'b0;
        end
    end

    // Parameter store; its contents are consumed by the MAC array outside this shell.
    always_ff @(posedge clk) begin
        if (para_accept) begin
            param_mem[para_addr] <= S_Data;
        end
        unused_param_q <= param_mem[para_addr];
    end

    assign unused_bits = ^{unused_param_q, cout, comp_prod[39:36], Reg_5[31:11],
                           Reg_6[15:5], Reg_7[31:24], Reg_7[15:0]};

    assign State_3_3       = st_c3;
    assign State_1_1       = st_c1;
    assign State_RE        = st_re;
    assign DMA_Read_Start  = rd_c3 | rd_c1 | rd_re;
    assign DMA_Write_Start = wr_c3 | wr_c1 | wr_re;
    assign M_Valid         = m_valid_q;
    assign M_Data          = m_data_q;

endmodule

// File: tb/tb_tjpu_ctrl_shell.sv
// Directed bench for tjpu_ctrl_shell with a queue scoreboard on the output stream.
module tb_tjpu_ctrl_shell;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   Switch, Control_3_3, Control_1_1;
    logic [7:0]   Control_RE;
    logic [3:0]   State_3_3, State_1_1, State_RE;
    logic [31:0]  Reg_4, Reg_5, Reg_6, Reg_7;
    logic         DMA_Read_Start, DMA_Write_Start;
    logic [127:0] S_Data, M_Data;
    logic         S_Valid, S_Ready, M_Valid, M_Ready;
    logic         introut_3x3_Wr;

    int           checks = 0;
    int           failures = 0;
    int           out_cnt = 0;
    int           rd_pulses = 0;
    int           wr_pulses = 0;
    logic [127:0] exp_q[$];
    bit           chk_const = 1'b0;
    logic [127:0] const_exp = '0;

    always #5 clk = ~clk;

    tjpu_ctrl_shell dut (
        .clk             (clk),
        .rst             (rst),
        .Switch          (Switch),
        .Control_3_3     (Control_3_3),
        .Control_1_1     (Control_1_1),
        .Control_RE      (Control_RE),
        .State_3_3       (State_3_3),
        .State_1_1       (State_1_1),
        .State_RE        (State_RE),
        .Reg_4           (Reg_4),
        .Reg_5           (Reg_5),
        .Reg_6           (Reg_6),
        .Reg_7           (Reg_7),
        .DMA_Read_Start  (DMA_Read_Start),
        .DMA_Write_Start (DMA_Write_Start),
        .S_Data          (S_Data),
        .S_Valid         (S_Valid),
        .S_Ready         (S_Ready),
        .M_Data          (M_Data),
        .M_Valid         (M_Valid),
        .M_Ready         (M_Ready),
        .introut_3x3_Wr  (introut_3x3_Wr)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference lane arithmetic in plain integers.
    function automatic logic [7:0] ref_lane(input logic [7:0] x, input logic [31:0] r6,
                                            input logic [31:0] r7);
        int xv;
        int sc;
        int zp;
        int v;
        xv = $signed(x);
        sc = $signed(r6[31:16]);
        zp = $signed(r7[23:16]);
        v  = (xv * sc) >>> r6[4:0];
        v  = v + zp;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v[7:0];
    endfunction

    function automatic logic [127:0] ref_beat(input logic [127:0] d);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = ref_lane(d[8*i +: 8], Reg_6, Reg_7);
        return y;
    endfunction

    // 0: non-negative lanes, 2: alternating 0x7F/0x80 lanes, otherwise fully random.
    function automatic logic [127:0] gen(input int mode);
        logic [127:0] d;
        d = '0;
        case (mode)
            0: for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'($urandom_range(0, 127));
            2: d = {8{8'h80, 8'h7F}};
            default: d = {$urandom(), $urandom(), $urandom(), $urandom()};
        endcase
        return d;
    endfunction

    // Output monitor: pops the scoreboard on every consumed output beat.
    always @(negedge clk) begin
        logic [127:0] e;
        if (DMA_Read_Start === 1'b1) rd_pulses++;
        if (DMA_Write_Start === 1'b1) wr_pulses++;
        if (!rst && M_Valid === 1'b1 && M_Ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL out_extra observed=%0h expected=none", M_Data);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", M_Data, e);
            end
            if (chk_const) chk("out_const", M_Data, const_exp);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cmd(input int eng, input logic [3:0] c);
        case (eng)
            0: Control_3_3 = c;
            1: Control_1_1 = c;
            default: Control_RE[7:4] = c;
        endcase
        @(posedge clk); #1;
        Control_3_3 = 4'h0;
        Control_1_1 = 4'h0;
        Control_RE[7:4] = 4'h0;
    endtask

    // Offer n beats; optionally stall the sink for 5 cycles once bp_at beats are in.
    task automatic stream(input int n, input bit comp, input bit pass, input int mode,
                          input int bp_at);
        int sent;
        int cyc;
        bit bp_done;
        sent = 0;
        cyc = 0;
        bp_done = 1'b0;
        S_Data = gen(mode);
        S_Valid = 1'b1;
        while (sent < n && cyc < 4 * n + 50) begin
            @(negedge clk);
            if (S_Ready === 1'b1) begin
                if (comp) exp_q.push_back(pass ? S_Data : ref_beat(S_Data));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            S_Data = gen(mode);
            if (bp_at > 0 && sent == bp_at && !bp_done && sent < n) begin
                M_Ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("bp_sready", S_Ready, 0);
                    chk("bp_mvalid", M_Valid, 1);
                    chk("bp_hold", M_Data, exp_q[$]);
                    @(posedge clk); #1;
                end
                M_Ready = 1'b1;
                bp_done = 1'b1;
            end
        end
        S_Valid = 1'b0;
        chk("stream_beats", sent, n);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (exp_q.size() != 0 && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int rd0;
        int wr0;
        int o0;
        Switch = 4'h0;
        Control_3_3 = 4'h0;
        Control_1_1 = 4'h0;
        Control_RE = 8'h00;
        Reg_4 = '0;
        Reg_5 = '0;
        Reg_6 = '0;
        Reg_7 = '0;
        S_Data = '0;
        S_Valid = 1'b0;
        M_Ready = 1'b1;
        introut_3x3_Wr = 1'bx;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state33", State_3_3, 0);
        chk("rst_state11", State_1_1, 0);
        chk("rst_statere", State_RE, 0);
        chk("rst_sready", S_Ready, 0);
        chk("rst_mvalid", M_Valid, 0);
        chk("rst_mdata", M_Data, 0);
        chk("rst_dma", {DMA_Read_Start, DMA_Write_Start}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // conv3x3 parameter load: 1024 + 32 beats
        Switch = 4'b0001;
        Reg_4 = 32'h04002001;
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        o0 = out_cnt;
        cmd(0, 4'b0001);
        chk("para_state", State_3_3, 4'b0001);
        chk("para_dma_rd", DMA_Read_Start, 1);
        stream(1056, 1'b0, 1'b0, 1, 0);
        chk("para_done", State_3_3, 4'b1111);
        chk("para_no_out", M_Valid, 0);
        @(posedge clk); #1;
        chk("para_done_x_no_clear", State_3_3, 4'b1111);
        chk("para_rd_pulses", rd_pulses - rd0, 1);
        chk("para_wr_pulses", wr_pulses - wr0, 0);
        chk("para_out_cnt", out_cnt - o0, 0);
        cmd(0, 4'b1111);
        chk("para_ack", State_3_3, 4'b0000);
        introut_3x3_Wr = 1'b0;

        // conv3x3 compute: 52*52*128/16 beats, every lane requantizes to 0x52
        Reg_4 = 32'h2001A080;
        Reg_5 = 32'h00000034;
        Reg_6 = 32'h10000815;
        Reg_7 = 32'h00520000;
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        o0 = out_cnt;
        const_exp = {16{8'h52}};
        chk_const = 1'b1;
        cmd(0, 4'b0010);
        chk("comp_state", State_3_3, 4'b0010);
        chk("comp_dma", {DMA_Read_Start, DMA_Write_Start}, 2'b11);
        stream(21632, 1'b1, 1'b0, 0, 0);
        chk("comp_done", State_3_3, 4'b1111);
        chk("comp_last_pending", M_Valid, 1);
        drain();
        chk_const = 1'b0;
        chk("comp_out_cnt", out_cnt - o0, 21632);
        chk("comp_rd_pulses", rd_pulses - rd0, 1);
        chk("comp_wr_pulses", wr_pulses - wr0, 1);
        introut_3x3_Wr = 1'b1;
        @(posedge clk); #1;
        introut_3x3_Wr = 1'b0;
        chk("comp_introut_ack", State_3_3, 4'b0000);

        // arithmetic corners: unity scale, then zero point pushing 0x7F into saturation
        Reg_4 = 32'h00000810;
        Reg_5 = 32'h00000002;
        Reg_6 = 32'h01000008;
        Reg_7 = 32'h00000000;
        const_exp = {8{8'h80, 8'h7F}};
        chk_const = 1'b1;
        cmd(0, 4'b0010);
        stream(2, 1'b1, 1'b0, 2, 0);
        drain();
        chk_const = 1'b0;
        cmd(0, 4'b1111);
        Reg_7 = 32'h00100000;
        const_exp = {8{8'h90, 8'h7F}};
        chk_const = 1'b1;
        cmd(0, 4'b0010);
        stream(2, 1'b1, 1'b0, 2, 0);
        drain();
        chk_const = 1'b0;
        cmd(0, 4'b1111);
        chk("arith_idle", State_3_3, 4'b0000);

        // backpressure mid-compute
        Reg_5 = 32'h00000008;
        Reg_7 = 32'h00000000;
        o0 = out_cnt;
        cmd(0, 4'b0010);
        stream(8, 1'b1, 1'b0, 1, 3);
        drain();
        chk("bp_out_cnt", out_cnt - o0, 8);
        chk("bp_done", State_3_3, 4'b1111);
        cmd(0, 4'b1111);

        // engine select: conv3x3 commands ignored while conv1x1 is selected
        Switch = 4'b0010;
        cmd(0, 4'b0001);
        chk("sel_33_ignored", State_3_3, 4'b0000);
        chk("sel_11_idle", State_1_1, 4'b0000);
        cmd(1, 4'b0001);
        chk("sel_11_para", State_1_1, 4'b0001);
        stream(8, 1'b0, 1'b0, 1, 0);
        chk("sel_11_done", State_1_1, 4'b1111);
        cmd(1, 4'b1111);
        chk("sel_11_ack", State_1_1, 4'b0000);

        // reshape maxpool passes data through unchanged
        Switch = 4'b1000;
        Control_RE[3:0] = 4'b0100;
        Reg_5 = 32'h00000002;
        Reg_6 = 32'h10000815;
        Reg_7 = 32'h00520000;
        cmd(2, 4'b0010);
        chk("re_comp", State_RE, 4'b0010);
        stream(2, 1'b1, 1'b1, 1, 0);
        drain();
        chk("re_done", State_RE, 4'b1111);
        cmd(2, 4'b1111);
        chk("re_ack", State_RE, 4'b0000);

        // reset in the middle of a compute run
        Switch = 4'b0001;
        Reg_5 = 32'h00000008;
        Reg_6 = 32'h01000008;
        Reg_7 = 32'h00000000;
        cmd(0, 4'b0010);
        stream(3, 1'b1, 1'b0, 1, 0);
        rst = 1'b1;
        #1;
        chk("midrst_state33", State_3_3, 4'b0000);
        chk("midrst_mvalid", M_Valid, 0);
        chk("midrst_sready", S_Ready, 0);
        chk("midrst_mdata", M_Data, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_state33", State_3_3, 4'b0000);
        chk("postrst_sready", S_Ready, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
